// File: rtl/rv32m_muldiv_unit.sv
// rv32m_muldiv_unit: RV32M execute unit. MUL* ops use a pipelined multiplier, DIV/REM ops an
// iterative restoring divider; single-issue start/busy/valid handshake for the hazard logic.
module rv32m_muldiv_unit #(
  parameter int XLEN          = 32,
  parameter int MUL_STAGES    = 2,
  parameter int DIV_RADIX_LOG = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            start,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            valid_out,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  localparam int NITER = XLEN / DIV_RADIX_LOG;
  localparam int CW    = (NITER > 1) ? $clog2(NITER) : 1;
  localparam int MD    = (MUL_STAGES > 1) ? MUL_STAGES - 1 : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PREP = 2'd1;
  localparam logic [1:0] S_ITER = 2'd2;

  logic [1:0]      r_state;
  logic [1:0]      r_f3;
  logic [4:0]      r_drd;
  logic            r_neg_q;
  logic            r_neg_r;
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_quo;
  logic [XLEN-1:0] r_dvs;
  logic [CW-1:0]   r_cnt;

  logic [MD-1:0]   r_mul_vld;
  logic [XLEN-1:0] r_mul_res [MD];
  logic [4:0]      r_mul_rd  [MD];

  logic              w_accept;
  logic              w_ma_sx;
  logic              w_mb_sx;
  logic [2*XLEN-1:0] w_ma;
  logic [2*XLEN-1:0] w_mb;
  logic [2*XLEN-1:0] w_mprod;
  logic [XLEN-1:0]   w_mul_sel;
  logic              w_mul_done;
  logic [XLEN-1:0]   w_mul_out;
  logic [4:0]        w_mul_rd;

  logic            w_sgn;
  logic            w_n1;
  logic            w_n2;
  logic            w_dz;
  logic            w_ovf;
  logic            w_spec;
  logic [XLEN-1:0] w_spec_res;
  logic [XLEN:0]   w_t;
  logic [XLEN-1:0] w_rem_n;
  logic [XLEN-1:0] w_quo_n;
  logic            w_last;
  logic [XLEN-1:0] w_q_fix;
  logic [XLEN-1:0] w_r_fix;
  logic            w_div_done;
  logic [XLEN-1:0] w_div_out;

  assign busy     = (r_state != S_IDLE) | (|r_mul_vld);
  assign w_accept = start & ~busy & ~flush;

  // Sign-extending both operands to 2*XLEN lets one unsigned multiply cover all four MUL flavours.
  assign w_ma_sx   = (func3[1:0] != 2'b11) & op1[XLEN-1];
  assign w_mb_sx   = ~func3[1] & op2[XLEN-1];
  assign w_ma      = {{XLEN{w_ma_sx}}, op1};
  assign w_mb      = {{XLEN{w_mb_sx}}, op2};
  assign w_mprod   = w_ma * w_mb;
  assign w_mul_sel = (func3[1:0] == 2'b00) ? w_mprod[XLEN-1:0] : w_mprod[2*XLEN-1:XLEN];

  // Multiplier pipeline: MUL_STAGES-1 stages, the output register provides the last one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mul_vld <= {MD{1'b0}};
      for (int i = 0; i < MD; i++) begin
        r_mul_res[i] <= {XLEN{1'b0}};
        r_mul_rd[i]  <= 5'd0;
      end
    end else if (flush) begin
      r_mul_vld <= {MD{1'b0}};
    end else begin
      r_mul_vld[0] <= w_accept & ~func3[2] & (MUL_STAGES > 1);
      if (w_accept) begin
        r_mul_res[0] <= w_mul_sel;
        r_mul_rd[0]  <= rd_in;
      end
      for (int i = 1; i < MD; i++) begin
        r_mul_vld[i] <= r_mul_vld[i-1];
        r_mul_res[i] <= r_mul_res[i-1];
        r_mul_rd[i]  <= r_mul_rd[i-1];
      end
    end
  end

  assign w_mul_done = (MUL_STAGES == 1) ? (w_accept & ~func3[2]) : r_mul_vld[MD-1];
  assign w_mul_out  = (MUL_STAGES == 1) ? w_mul_sel : r_mul_res[MD-1];
  assign w_mul_rd   = (MUL_STAGES == 1) ? rd_in : r_mul_rd[MD-1];

  // In PREP r_quo/r_dvs still hold the raw operands captured at accept.
  assign w_sgn      = ~r_f3[0];
  assign w_n1       = w_sgn & r_quo[XLEN-1];
  assign w_n2       = w_sgn & r_dvs[XLEN-1];
  assign w_dz       = (r_dvs == {XLEN{1'b0}});
  assign w_ovf      = w_sgn & (r_quo == {1'b1, {(XLEN-1){1'b0}}}) & (r_dvs == {XLEN{1'b1}});
  assign w_spec     = w_dz | w_ovf;
  assign w_spec_res = r_f3[1] ? (w_dz ? r_quo : {XLEN{1'b0}})
                              : (w_dz ? {XLEN{1'b1}} : r_quo);

  // Restoring shift-subtract, DIV_RADIX_LOG quotient bits per cycle.
  always_comb begin
    w_rem_n = r_rem;
    w_quo_n = r_quo;
    w_t     = {(XLEN+1){1'b0}};
    for (int k = 0; k < DIV_RADIX_LOG; k++) begin
      w_t     = {w_rem_n, w_quo_n[XLEN-1]};
      w_quo_n = {w_quo_n[XLEN-2:0], 1'b0};
      if (w_t >= {1'b0, r_dvs}) begin
        w_t        = w_t - {1'b0, r_dvs};
        w_quo_n[0] = 1'b1;
      end else begin
        w_quo_n[0] = 1'b0;
      end
      w_rem_n = w_t[XLEN-1:0];
    end
  end

  // Sign fix-up is folded into the last iteration edge so that result lands at XLEN/k+2.
  assign w_last     = (r_cnt == CW'(NITER - 1));
  assign w_q_fix    = r_neg_q ? -w_quo_n : w_quo_n;
  assign w_r_fix    = r_neg_r ? -w_rem_n : w_rem_n;
  assign w_div_done = ((r_state == S_PREP) & w_spec) | ((r_state == S_ITER) & w_last);
  assign w_div_out  = (r_state == S_PREP) ? w_spec_res : (r_f3[1] ? w_r_fix : w_q_fix);

  // Divider FSM: IDLE -> PREP -> ITER -> IDLE, specials leave directly from PREP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_f3    <= 2'b00;
      r_drd   <= 5'd0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_rem   <= {XLEN{1'b0}};
      r_quo   <= {XLEN{1'b0}};
      r_dvs   <= {XLEN{1'b0}};
      r_cnt   <= {CW{1'b0}};
    end else if (flush) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept & func3[2]) begin
            r_state <= S_PREP;
            r_f3    <= func3[1:0];
            r_drd   <= rd_in;
            r_quo   <= op1;
            r_dvs   <= op2;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_PREP: begin
          r_neg_q <= w_n1 ^ w_n2;
          r_neg_r <= w_n1;
          r_quo   <= w_n1 ? -r_quo : r_quo;
          r_dvs   <= w_n2 ? -r_dvs : r_dvs;
          r_rem   <= {XLEN{1'b0}};
          r_cnt   <= {CW{1'b0}};
          r_state <= w_spec ? S_IDLE : S_ITER;
        end
        S_ITER: begin
          r_rem   <= w_rem_n;
          r_quo   <= w_quo_n;
          r_cnt   <= r_cnt + CW'(1);
          r_state <= w_last ? S_IDLE : S_ITER;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Output register: result/rd_out hold their value between completions.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_out <= 1'b0;
      result    <= {XLEN{1'b0}};
      rd_out    <= 5'd0;
    end else if (flush) begin
      valid_out <= 1'b0;
    end else if (w_mul_done) begin
      valid_out <= 1'b1;
      result    <= w_mul_out;
      rd_out    <= w_mul_rd;
    end else if (w_div_done) begin
      valid_out <= 1'b1;
      result    <= w_div_out;
      rd_out    <= r_drd;
    end else begin
      valid_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rv32m_muldiv_unit.sv
// Randomized scoreboard bench for rv32m_muldiv_unit: a driver pushes expected results from an
// arithmetic reference model, a negedge monitor pops and compares every valid_out.
module tb_rv32m_muldiv_unit;

  localparam int MUL_ST = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush, start;
  logic [2:0]  func3;
  logic [31:0] op1, op2;
  logic [4:0]  rd_in;
  logic        busy, valid_out;
  logic [31:0] result;
  logic [4:0]  rd_out;

  logic        start4;
  logic [2:0]  func3_4;
  logic [31:0] op1_4, op2_4;
  logic [4:0]  rd_in4;
  logic        busy4, valid4;
  logic [31:0] result4;
  logic [4:0]  rd_out4;

  always #5 clk = ~clk;

  rv32m_muldiv_unit #(.XLEN(32), .MUL_STAGES(MUL_ST), .DIV_RADIX_LOG(1)) u_dut (
    .clk(clk), .rst(rst), .flush(flush), .start(start), .func3(func3),
    .op1(op1), .op2(op2), .rd_in(rd_in), .busy(busy), .valid_out(valid_out),
    .result(result), .rd_out(rd_out));

  rv32m_muldiv_unit #(.XLEN(32), .MUL_STAGES(MUL_ST), .DIV_RADIX_LOG(2)) u_dut4 (
    .clk(clk), .rst(rst), .flush(1'b0), .start(start4), .func3(func3_4),
    .op1(op1_4), .op2(op2_4), .rd_in(rd_in4), .busy(busy4), .valid_out(valid4),
    .result(result4), .rd_out(rd_out4));

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          due;
  } exp_t;

  exp_t        q[$];
  int          cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] last_res = 32'd0;
  logic [4:0]  last_rd = 5'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
    logic signed [63:0] sa, sb, ub, ps;
    logic [63:0]        pu;
    logic signed [31:0] s1, s2, sq;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ub = {32'd0, b};
    s1 = a;
    s2 = b;
    case (f3)
      3'b000: begin ps = sa * sb; return ps[31:0]; end
      3'b001: begin ps = sa * sb; return ps[63:32]; end
      3'b010: begin ps = sa * ub; return ps[63:32]; end
      3'b011: begin pu = {32'd0, a} * {32'd0, b}; return pu[63:32]; end
      3'b100: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        sq = s1 / s2; return sq;
      end
      3'b101: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        sq = s1 % s2; return sq;
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] b, input int rlog);
    if (!f3[2]) return MUL_ST;
    if (b == 32'd0) return 2;
    if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
    return 32 / rlog + 2;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(7, 0))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(15, 0));
      4: return -32'($urandom_range(15, 1));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: every valid_out must match the oldest outstanding expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst) begin
      if (valid_out) begin
        if (q.size() == 0) begin
          check("unexpected_valid", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          check("result", result, e.res);
          check("rd_out", {27'd0, rd_out}, {27'd0, e.rd});
          check("latency", cyc, e.due);
          check("busy_at_valid", {31'd0, busy}, 32'd0);
          last_res = e.res;
          last_rd  = e.rd;
        end
      end else begin
        check("hold_result", result, last_res);
        check("hold_rd", {27'd0, rd_out}, {27'd0, last_rd});
      end
    end
  end

  // Issue one op at the current negedge and return at the negedge of its completion cycle.
  // flush_at: -1 none, 0 random cycle, k>0 flush during cycle T+k. repulse: extra start at T+5.
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input int flush_at, input bit repulse);
    int   lat;
    int   fk;
    exp_t e;
    lat = exp_lat(f3, a, b, 1);
    fk  = flush_at;
    if (fk == 0) fk = (lat > 1) ? int'($urandom_range(lat - 1, 1)) : -1;
    start = 1'b1; func3 = f3; op1 = a; op2 = b; rd_in = rd;
    e.res = ref_model(f3, a, b); e.rd = rd; e.due = cyc + lat;
    q.push_back(e);
    @(negedge clk);
    start = 1'b0; func3 = 3'($urandom); op1 = $urandom; op2 = $urandom; rd_in = 5'($urandom);
    if (lat > 1) check("busy_after_accept", {31'd0, busy}, 32'd1);
    for (int k = 1; k < lat; k++) begin
      if (k == fk) begin
        flush = 1'b1;
        if (q.size() > 0) void'(q.pop_back());
        @(negedge clk);
        flush = 1'b0;
        check("busy_after_flush", {31'd0, busy}, 32'd0);
        return;
      end else if (repulse && k == 5) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end else begin
        @(negedge clk);
      end
    end
  endtask

  task automatic reset_mid(input int at);
    start = 1'b1; func3 = 3'b100; op1 = 32'd1000; op2 = 32'd7; rd_in = 5'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (at - 1) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_mid_valid", {31'd0, valid_out}, 32'd0);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_result", result, 32'd0);
    check("rst_mid_rd", {27'd0, rd_out}, 32'd0);
    last_res = 32'd0;
    last_rd  = 5'd0;
    @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
  endtask

  task automatic div4(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] rd);
    int c;
    int n;
    start4 = 1'b1; func3_4 = f3; op1_4 = a; op2_4 = b; rd_in4 = rd;
    c = cyc;
    @(negedge clk);
    start4 = 1'b0;
    n = 1;
    while (!valid4 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!valid4) begin
      check("radix4_timeout", 32'd0, 32'd1);
    end else begin
      check("radix4_result", result4, ref_model(f3, a, b));
      check("radix4_rd", {27'd0, rd_out4}, {27'd0, rd});
      check("radix4_latency", cyc - c, exp_lat(f3, a, b, 2));
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; start = 1'b0; func3 = 3'd0; op1 = 32'd0; op2 = 32'd0;
    rd_in = 5'd0; start4 = 1'b0; func3_4 = 3'd0; op1_4 = 32'd0; op2_4 = 32'd0; rd_in4 = 5'd0;
    repeat (3) @(negedge clk);
    check("reset_valid", {31'd0, valid_out}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_result", result, 32'd0);
    check("reset_rd", {27'd0, rd_out}, 32'd0);
    check("reset_valid4", {31'd0, valid4}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    issue(3'b001, 32'hFFFF_FFFF, 32'd2, 5'd1, -1, 1'b0);
    issue(3'b000, 32'hFFFF_FFFF, 32'd2, 5'd2, -1, 1'b0);
    issue(3'b100, -32'd7, 32'd2, 5'd3, -1, 1'b0);
    issue(3'b110, -32'd7, 32'd2, 5'd4, -1, 1'b0);
    issue(3'b101, 32'h1234, 32'd0, 5'd5, -1, 1'b0);
    issue(3'b111, 32'h1234, 32'd0, 5'd6, -1, 1'b0);
    issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, -1, 1'b0);
    issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, -1, 1'b0);
    issue(3'b110, -32'd5, 32'd0, 5'd10, -1, 1'b0);
    issue(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd11, -1, 1'b0);
    issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd12, -1, 1'b0);
    issue(3'b101, 32'hDEAD_BEEF, 32'd13, 5'd13, -1, 1'b1);
    issue(3'b100, 32'd100, 32'd7, 5'd14, 10, 1'b0);
    issue(3'b000, 32'd6, 32'd7, 5'd15, -1, 1'b0);
    issue(3'b001, 32'd6, 32'd7, 5'd16, 1, 1'b0);
    issue(3'b000, 32'd9, 32'd9, 5'd17, -1, 1'b0);

    start = 1'b1; flush = 1'b1; func3 = 3'b000; op1 = 32'd3; op2 = 32'd3; rd_in = 5'd18;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    repeat (4) @(negedge clk);

    reset_mid(4);

    for (int i = 0; i < 150; i++) begin
      issue(3'($urandom_range(7, 0)), pick(), pick(), 5'($urandom),
            ($urandom_range(9, 0) == 0) ? 0 : -1, ($urandom_range(7, 0) == 0));
      if ($urandom_range(3, 0) == 0) @(negedge clk);
    end

    repeat (40) @(negedge clk);
    check("pending_at_end", q.size(), 32'd0);

    div4(3'b100, -32'd7, 32'd2, 5'd21);
    div4(3'b110, -32'd7, 32'd2, 5'd22);
    div4(3'b101, 32'h1234, 32'd0, 5'd23);
    for (int i = 0; i < 20; i++) begin
      div4(3'($urandom_range(7, 4)), pick(), pick(), 5'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
